// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } imem_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  // NOP (sll $0,$0,0) is all-zeros; replicate this fill bit over WIDTH.
  function automatic logic IMEM_NOP();
    return 1'b0;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// CPU fetch port of the instruction memory: master is the fetch stage, slave is the memory.
interface imem_loader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
);
  logic             fetch_en;
  logic [AW+1:0]    pc;
  logic [WIDTH-1:0] instr_out;
  logic             instr_valid;
  logic             fetch_err;

  modport master (output fetch_en, pc, input instr_out, instr_valid, fetch_err);
  modport slave  (input fetch_en, pc, output instr_out, instr_valid, fetch_err);
endinterface

// File: rtl/imem_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port, no reset.
module imem_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Serially loaded instruction memory with checked, registered CPU fetch.
// Optional IMEM_CHECKSUM_EN adds an XOR checksum of the words accepted in the current session.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             LoadInstructions,
  input  logic [WIDTH-1:0] Instruction,
  imem_loader_if.slave     fetch,
  output logic [AW:0]      prog_len,
  output logic             full,
  output logic             load_ovf
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum
`endif
);

  imem_state_t      state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, ptr;
  logic [AW:0]      prog_len_q = '0;
  logic [AW:0]      prog_len_d;
  logic             load_ovf_q, load_ovf_d;
  logic             valid_q, valid_d, err_q, err_d, sel_q, sel_d;
  logic [1:0]       cause;
  logic             we, re;
  logic [WIDTH-1:0] rdata;
`ifdef IMEM_CHECKSUM_EN
  logic [WIDTH-1:0] cks_q, cks_d, cks_base;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    load_ovf_d = load_ovf_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    sel_d      = 1'b0;
    cause      = ERR_NONE;
    we         = 1'b0;
    re         = 1'b0;
    ptr        = (state_q == LOAD) ? wr_ptr_q : '0;
`ifdef IMEM_CHECKSUM_EN
    cks_base   = (state_q == LOAD) ? cks_q : '0;
    cks_d      = cks_q;
`endif
    if (LoadInstructions) begin
      state_d = LOAD;
      if (state_q != LOAD) begin
        prog_len_d = '0;
        load_ovf_d = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        cks_d      = '0;
`endif
      end
      if (ptr == (AW+1)'(DEPTH)) begin
        load_ovf_d = 1'b1;
      end else begin
        we         = 1'b1;
        wr_ptr_d   = ptr + (AW+1)'(1);
        prog_len_d = ptr + (AW+1)'(1);
`ifdef IMEM_CHECKSUM_EN
        cks_d      = cks_base ^ Instruction;
`endif
      end
    end else begin
      // IDLE also falls through to RUN so a program survives a Reset pulse.
      if (state_q != RUN) state_d = RUN;
      if (state_q == RUN && fetch.fetch_en) begin
        valid_d = 1'b1;
        if (fetch.pc[1:0] != 2'b00) cause = ERR_MISALIGN;
        else if ({1'b0, fetch.pc[AW+1:2]} >= prog_len_q) cause = ERR_RANGE;
        err_d = (cause != ERR_NONE);
        sel_d = ~err_d;
        re    = sel_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      load_ovf_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      load_ovf_q <= load_ovf_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      sel_q      <= sel_d;
`ifdef IMEM_CHECKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  imem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we & ~Reset),
    .waddr (ptr[AW-1:0]),
    .wdata (Instruction),
    .re    (re),
    .raddr (fetch.pc[AW+1:2]),
    .rdata (rdata)
  );

  // RAM output is unreset; the registered select forces NOP after reset and on errors.
  assign fetch.instr_out   = sel_q ? rdata : {WIDTH{IMEM_NOP()}};
  assign fetch.instr_valid = valid_q;
  assign fetch.fetch_err   = err_q;
  assign prog_len          = prog_len_q;
  assign full              = (prog_len_q == (AW+1)'(DEPTH));
  assign load_ovf          = load_ovf_q;
`ifdef IMEM_CHECKSUM_EN
  assign checksum          = cks_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (WIDTH=32, DEPTH=64).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        Reset;
  logic        LoadInstructions;
  logic [31:0] Instruction;
  logic [6:0]  prog_len;
  logic        full;
  logic        load_ovf;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  imem_loader_if #(.WIDTH(32), .DEPTH(64)) fetch_if ();

  imem_loader #(
    .WIDTH (32),
    .DEPTH (64)
  ) dut (
    .clk              (clk),
    .Reset            (Reset),
    .LoadInstructions (LoadInstructions),
    .Instruction      (Instruction),
    .fetch            (fetch_if),
    .prog_len         (prog_len),
    .full             (full),
    .load_ovf         (load_ovf)
`ifdef IMEM_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] data, input logic err);
    check({tag, ".data"},  64'(fetch_if.instr_out),   64'(data));
    check({tag, ".valid"}, 64'(fetch_if.instr_valid), 64'd1);
    check({tag, ".err"},   64'(fetch_if.fetch_err),   64'(err));
  endtask

  logic [31:0] prog [5];

  initial begin
    prog[0] = 32'h200101A7; prog[1] = 32'h2002005C; prog[2] = 32'h2003000D;
    prog[3] = 32'h20040092; prog[4] = 32'h20050005;
    Reset = 1'b1; LoadInstructions = 1'b0; Instruction = '0;
    fetch_if.fetch_en = 1'b0; fetch_if.pc = '0;
    tick();
    Reset = 1'b0;
    check("rst.instr_out", 64'(fetch_if.instr_out), 64'd0);
    check("rst.valid", 64'(fetch_if.instr_valid), 64'd0);
    check("rst.err", 64'(fetch_if.fetch_err), 64'd0);
    check("rst.ovf", 64'(load_ovf), 64'd0);
    check("rst.prog_len", 64'(prog_len), 64'd0);
    check("rst.full", 64'(full), 64'd0);

    // Basic load, then Reset, then run
    LoadInstructions = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Instruction = prog[i];
      tick();
      if (i == 0) check("load.first_len", 64'(prog_len), 64'd1);
    end
    LoadInstructions = 1'b0;
    tick();
    check("load.prog_len", 64'(prog_len), 64'd5);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst2.prog_len", 64'(prog_len), 64'd5);
    tick();
    fetch_if.fetch_en = 1'b1;
    fetch_if.pc = 7'd0;  tick(); check_fetch("pc0", 32'h200101A7, 1'b0);
    fetch_if.pc = 7'd4;  tick(); check_fetch("pc4", 32'h2002005C, 1'b0);
    fetch_if.pc = 7'd16; tick(); check_fetch("pc16", 32'h20050005, 1'b0);
    fetch_if.pc = 7'd20; tick(); check_fetch("pc20_range", 32'h0, 1'b1);
    fetch_if.pc = 7'd6;  tick(); check_fetch("pc6_misalign", 32'h0, 1'b1);
    fetch_if.fetch_en = 1'b0;
    tick();
    check("drop.valid", 64'(fetch_if.instr_valid), 64'd0);

    // Overflow: 66 words into 64 slots
    LoadInstructions = 1'b1;
    for (int i = 0; i < 66; i++) begin
      Instruction = 32'(i);
      tick();
    end
    check("ovf.prog_len", 64'(prog_len), 64'd64);
    check("ovf.full", 64'(full), 64'd1);
    check("ovf.flag", 64'(load_ovf), 64'd1);
    LoadInstructions = 1'b0;
    tick();
    fetch_if.fetch_en = 1'b1;
    fetch_if.pc = 8'd252; tick(); check_fetch("ovf.pc252", 32'd63, 1'b0);
    fetch_if.pc = 8'd4;   tick(); check_fetch("ovf.pc4", 32'd1, 1'b0);
    fetch_if.fetch_en = 1'b0;
    LoadInstructions = 1'b1;
    Instruction = 32'h0000_1234;
    tick();
    LoadInstructions = 1'b0;
    check("ovf.new_len", 64'(prog_len), 64'd1);
    check("ovf.cleared", 64'(load_ovf), 64'd0);
    check("ovf.not_full", 64'(full), 64'd0);
    tick();

    // Reset mid-load
    LoadInstructions = 1'b1;
    Instruction = 32'h11; tick();
    Instruction = 32'h22; tick();
    Instruction = 32'h33; tick();
    Instruction = 32'h44;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    LoadInstructions = 1'b0;
    check("midrst.prog_len", 64'(prog_len), 64'd3);
    tick();
    fetch_if.fetch_en = 1'b1;
    fetch_if.pc = 8'd12; tick(); check_fetch("midrst.pc12", 32'h0, 1'b1);
    fetch_if.pc = 8'd0;  tick(); check_fetch("midrst.pc0", 32'h11, 1'b0);
    fetch_if.pc = 8'd4;  tick(); check_fetch("midrst.pc4", 32'h22, 1'b0);
    fetch_if.pc = 8'd8;  tick(); check_fetch("midrst.pc8", 32'h33, 1'b0);

    // Load beats fetch: fetch_en stays high through the session
    fetch_if.pc = 8'd0;
    LoadInstructions = 1'b1;
    Instruction = 32'hCAFE0001; tick();
    check("lbf.valid0", 64'(fetch_if.instr_valid), 64'd0);
    Instruction = 32'hCAFE0002; tick();
    check("lbf.valid1", 64'(fetch_if.instr_valid), 64'd0);
    LoadInstructions = 1'b0;
    tick();
    check("lbf.exit_valid", 64'(fetch_if.instr_valid), 64'd0);
    tick();
    check_fetch("lbf.first", 32'hCAFE0001, 1'b0);
    fetch_if.fetch_en = 1'b0;
    tick();
    check("lbf.drop_valid", 64'(fetch_if.instr_valid), 64'd0);
    check("lbf.drop_data", 64'(fetch_if.instr_out), 64'd0);

`ifdef IMEM_CHECKSUM_EN
    LoadInstructions = 1'b1;
    Instruction = 32'hA5A5A5A5; tick();
    Instruction = 32'h0F0F0F0F; tick();
    check("cks.value", 64'(checksum), 64'hAAAAAAAA);
    LoadInstructions = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("cks.reset", 64'(checksum), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
